// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared state/owner encodings and default starvation limit for cache_port_arbiter
package cache_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_BUSY_C = 2'd1, ARB_BUSY_L = 2'd2} arb_state_t;
  typedef enum logic {OWN_C = 1'b0, OWN_L = 1'b1} arb_owner_t;
  localparam int DEF_MAX_WAIT = 8;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating 8-bit loader starvation counter with clear and saturate flag
module arb_wait_counter import cache_arb_pkg::*; #(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt,
  output logic       sat
);
  assign sat = cnt == 8'(MAX_WAIT);
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? 8'd0 : (inc && !sat) ? cnt + 8'd1 : cnt;
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: core/loader arbiter for the cache data port; CACHE_ARB_STATS_EN adds grant/conflict counters
module cache_port_arbiter import cache_arb_pkg::*; #(
  parameter int MAX_WAIT = DEF_MAX_WAIT
`ifdef CACHE_ARB_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_mem_read,
  input  logic        c_mem_write,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        l_mem_read,
  input  logic        l_mem_write,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_stall,
  output logic        m_mem_read,
  output logic        m_mem_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_stall
`ifdef CACHE_ARB_STATS_EN
  , output logic [CNT_W-1:0] grant_cnt_c
  , output logic [CNT_W-1:0] grant_cnt_l
  , output logic [CNT_W-1:0] conflict_cnt
`endif
);
  arb_state_t state;
  arb_owner_t own;
  logic c_req, l_req, act, o_rd, o_wr, done, w_sat;
  logic [7:0] wait_cnt;
  assign c_req = c_mem_read | c_mem_write;
  assign l_req = l_mem_read | l_mem_write;
  assign act = !reset && (state != ARB_IDLE || c_req || l_req);
  always_comb
    own = (state == ARB_BUSY_L || (state == ARB_IDLE && l_req && (w_sat || !c_req))) ? OWN_L : OWN_C;
  assign o_rd = own == OWN_L ? l_mem_read : c_mem_read;
  assign o_wr = own == OWN_L ? l_mem_write : c_mem_write;
  assign m_mem_read = act & o_rd;
  assign m_mem_write = act & o_wr & ~o_rd;
  assign m_addr = act ? (own == OWN_L ? l_addr : c_addr) : '0;
  assign m_wdata = act ? (own == OWN_L ? l_wdata : c_wdata) : '0;
  assign c_rdata = reset ? '0 : m_rdata;
  assign l_rdata = reset ? '0 : m_rdata;
  assign c_stall = act && (own == OWN_C ? m_stall : c_req);
  assign l_stall = act && (own == OWN_L ? m_stall : l_req);
  assign done = act && !m_stall;
  always_ff @(posedge clk)
    state <= (reset || !m_stall) ? ARB_IDLE : state != ARB_IDLE ? state : !act ? ARB_IDLE : own == OWN_L ? ARB_BUSY_L : ARB_BUSY_C;
  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (l_req && own != OWN_L),
    .clr   (!l_req || (done && own == OWN_L)),
    .cnt   (wait_cnt),
    .sat   (w_sat)
  );
`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    grant_cnt_c <= reset ? '0 : grant_cnt_c + CNT_W'(done && own == OWN_C);
    grant_cnt_l <= reset ? '0 : grant_cnt_l + CNT_W'(done && own == OWN_L);
    conflict_cnt <= reset ? '0 : conflict_cnt + CNT_W'(c_req && l_req);
  end
`endif
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed scenarios plus randomized traffic against a transaction-level ownership model
module tb_cache_port_arbiter;
  logic clk = 0, reset = 1;
  logic c_mem_read = 0, c_mem_write = 0, l_mem_read = 0, l_mem_write = 0, m_stall = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, l_addr = 0, l_wdata = 0, m_rdata = 0;
  logic [31:0] c_rdata, l_rdata, m_addr, m_wdata;
  logic c_stall, l_stall, m_mem_read, m_mem_write;
`ifdef CACHE_ARB_STATS_EN
  logic [31:0] grant_cnt_c, grant_cnt_l, conflict_cnt;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  cache_port_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .c_mem_read(c_mem_read), .c_mem_write(c_mem_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .l_mem_read(l_mem_read), .l_mem_write(l_mem_write), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_stall(l_stall),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_stall(m_stall)
`ifdef CACHE_ARB_STATS_EN
    , .grant_cnt_c(grant_cnt_c), .grant_cnt_l(grant_cnt_l), .conflict_cnt(conflict_cnt)
`endif
  );
  task automatic drive(input logic crd, cwr, input logic [31:0] ca, cd,
                       input logic lrd, lwr, input logic [31:0] la, ld,
                       input logic ms, input logic [31:0] rd);
    @(negedge clk);
    c_mem_read = crd; c_mem_write = cwr; c_addr = ca; c_wdata = cd;
    l_mem_read = lrd; l_mem_write = lwr; l_addr = la; l_wdata = ld;
    m_stall = ms; m_rdata = rd;
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    drive(1, 0, 32'h10, 32'h11, 0, 1, 32'h20, 32'h21, 1, 32'hABCD);
    total++; if ({m_mem_read, m_mem_write, c_stall, l_stall} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {m_mem_read, m_mem_write, c_stall, l_stall}); else passed++;
    total++; if ({m_addr, m_wdata, c_rdata} !== 96'h0) $display("FAIL reset_mux got %h want 0", {m_addr, m_wdata, c_rdata}); else passed++;
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5);
    total++; if ({m_mem_read, m_mem_write, m_addr, m_wdata} !== 66'h0) $display("FAIL idle_outputs got %h want 0", {m_mem_read, m_mem_write, m_addr, m_wdata}); else passed++;
`ifdef CACHE_ARB_STATS_EN
    total++; if ({grant_cnt_c, grant_cnt_l, conflict_cnt} !== 96'h0) $display("FAIL reset_counters got %h want 0", {grant_cnt_c, grant_cnt_l, conflict_cnt}); else passed++;
`endif
  endtask
  task automatic test_core_hit();
    do_reset();
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 32'hDEAD);
    total++; if ({m_mem_read, m_mem_write, c_stall} !== 3'b100) $display("FAIL hit_strobes got %b want 100", {m_mem_read, m_mem_write, c_stall}); else passed++;
    total++; if (m_addr !== 32'h100) $display("FAIL hit_addr got %h want 100", m_addr); else passed++;
    total++; if (c_rdata !== 32'hDEAD) $display("FAIL hit_rdata got %h want dead", c_rdata); else passed++;
    drive(0, 0, 0, 0, 1, 0, 32'h200, 0, 0, 0);
    total++; if ({m_mem_read, m_addr, l_stall} !== {1'b1, 32'h200, 1'b0}) $display("FAIL hit_then_idle got %h want %h", {m_mem_read, m_addr, l_stall}, {1'b1, 32'h200, 1'b0}); else passed++;
  endtask
  task automatic test_miss();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h40, 32'h55, i > 0, 0, 32'h80, 0, 1, 0);
      total++; if ({m_mem_write, m_mem_read, c_stall, m_addr, m_wdata} !== {3'b101, 32'h40, 32'h55}) $display("FAIL miss_fwd%0d got %h want %h", i, {m_mem_write, m_mem_read, c_stall, m_addr, m_wdata}, {3'b101, 32'h40, 32'h55}); else passed++;
      total++; if (l_stall !== (i > 0)) $display("FAIL miss_lstall%0d got %b want %b", i, l_stall, i > 0); else passed++;
    end
    drive(0, 1, 32'h40, 32'h55, 1, 0, 32'h80, 0, 0, 0);
    total++; if ({m_mem_write, c_stall, l_stall, m_addr} !== {3'b101, 32'h40}) $display("FAIL miss_done got %h want %h", {m_mem_write, c_stall, l_stall, m_addr}, {3'b101, 32'h40}); else passed++;
    drive(0, 0, 0, 0, 1, 0, 32'h80, 0, 0, 0);
    total++; if ({m_mem_read, l_stall, m_addr} !== {2'b10, 32'h80}) $display("FAIL miss_loader_next got %h want %h", {m_mem_read, l_stall, m_addr}, {2'b10, 32'h80}); else passed++;
  endtask
  task automatic test_simultaneous();
    do_reset();
    drive(1, 0, 32'hC0, 0, 1, 0, 32'hD0, 0, 0, 0);
    total++; if ({m_addr, c_stall, l_stall} !== {32'hC0, 2'b01}) $display("FAIL simul_core got %h want %h", {m_addr, c_stall, l_stall}, {32'hC0, 2'b01}); else passed++;
    drive(0, 0, 0, 0, 1, 0, 32'hD0, 0, 0, 0);
    total++; if ({m_addr, l_stall} !== {32'hD0, 1'b0}) $display("FAIL simul_loader got %h want %h", {m_addr, l_stall}, {32'hD0, 1'b0}); else passed++;
  endtask
  task automatic test_starvation();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 32'hA00 + i, 0, 0, 1, 32'hB00, 32'h77, 0, 0);
      if (i == 9) begin
        total++; if ({m_addr, m_mem_write, l_stall, c_stall} !== {32'hB00, 3'b101}) $display("FAIL starve_grant got %h want %h", {m_addr, m_mem_write, l_stall, c_stall}, {32'hB00, 3'b101}); else passed++;
      end else begin
        total++; if ({m_addr, l_stall} !== {32'hA00 + i, 1'b1}) $display("FAIL starve_core%0d got %h want %h", i, {m_addr, l_stall}, {32'hA00 + i, 1'b1}); else passed++;
      end
    end
  endtask
  task automatic test_reset_busy_l();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 32'h300, 32'h9, 1, 0);
    drive(1, 0, 32'h400, 0, 0, 1, 32'h300, 32'h9, 1, 0);
    total++; if ({m_addr, m_mem_write, c_stall, l_stall} !== {32'h300, 3'b111}) $display("FAIL busyl_hold got %h want %h", {m_addr, m_mem_write, c_stall, l_stall}, {32'h300, 3'b111}); else passed++;
    reset = 1;
    drive(1, 0, 32'h400, 0, 0, 1, 32'h300, 32'h9, 1, 0);
    total++; if ({m_mem_read, m_mem_write, c_stall, l_stall} !== 4'b0) $display("FAIL busyl_reset got %b want 0000", {m_mem_read, m_mem_write, c_stall, l_stall}); else passed++;
    reset = 0;
    drive(1, 0, 32'h400, 0, 0, 1, 32'h300, 32'h9, 0, 0);
    total++; if ({m_addr, m_mem_read, l_stall} !== {32'h400, 2'b11}) $display("FAIL busyl_after got %h want %h", {m_addr, m_mem_read, l_stall}, {32'h400, 2'b11}); else passed++;
`ifdef CACHE_ARB_STATS_EN
    total++; if ({grant_cnt_c, grant_cnt_l, conflict_cnt} !== 96'h0) $display("FAIL busyl_counters got %h want 0", {grant_cnt_c, grant_cnt_l, conflict_cnt}); else passed++;
`endif
  endtask
`ifdef CACHE_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    drive(1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h2, 0, 1, 0, 32'h5, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h5, 0, 0, 0);
    drive(1, 0, 32'h3, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h6, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if ({grant_cnt_c, grant_cnt_l, conflict_cnt} !== {32'd3, 32'd2, 32'd1}) $display("FAIL stats got %0d/%0d/%0d want 3/2/1", grant_cnt_c, grant_cnt_l, conflict_cnt); else passed++;
  endtask
`endif
  task automatic test_random();
    int owner = 0, waited = 0, w;
    logic crd = 0, cwr = 0, lrd = 0, lwr = 0, ms, hc = 0, hl = 0, creq, lreq;
    logic [31:0] ca = 0, cd = 0, la = 0, ld = 0, rd;
    logic [100:0] got, exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!hc) begin
        crd = $urandom_range(0, 9) < 4; cwr = $urandom_range(0, 9) < 3;
        ca = $urandom; cd = $urandom;
      end
      if (!hl) begin
        lrd = $urandom_range(0, 9) < 3; lwr = $urandom_range(0, 9) < 3;
        la = $urandom; ld = $urandom;
      end
      ms = $urandom_range(0, 3) == 0; rd = $urandom;
      drive(crd, cwr, ca, cd, lrd, lwr, la, ld, ms, rd);
      creq = crd | cwr; lreq = lrd | lwr;
      w = owner != 0 ? owner : (lreq && (waited >= 8 || !creq)) ? 2 : creq ? 1 : 0;
      exp = {w == 1 ? crd : w == 2 ? lrd : 1'b0,
             w == 1 ? (cwr & ~crd) : w == 2 ? (lwr & ~lrd) : 1'b0,
             w == 1 ? ca : w == 2 ? la : 32'h0,
             w == 1 ? cd : w == 2 ? ld : 32'h0,
             w == 1 ? ms : creq, w == 2 ? ms : lreq, rd};
      got = {m_mem_read, m_mem_write, m_addr, m_wdata, c_stall, l_stall, c_rdata};
      total++; if (got !== exp || l_rdata !== rd) $display("FAIL random%0d got %h want %h", n, got, exp); else passed++;
      hc = exp[33]; hl = exp[32];
      if (!lreq || (w == 2 && !ms)) waited = 0;
      else if (w != 2 && waited < 8) waited++;
      if (w != 0) owner = ms ? w : 0;
    end
  endtask
  initial begin
    test_reset();
    test_core_hit();
    test_miss();
    test_simultaneous();
    test_starvation();
    test_reset_busy_l();
`ifdef CACHE_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
